// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, pixel types and helpers for the VGA block.
package vga_pkg;

    // Default SVGA 800x600@72 geometry
    localparam int SVGA_H_ACT = 800;
    localparam int SVGA_H_FP  = 56;
    localparam int SVGA_H_SW  = 120;
    localparam int SVGA_H_BP  = 64;
    localparam int SVGA_V_ACT = 600;
    localparam int SVGA_V_FP  = 37;
    localparam int SVGA_V_SW  = 6;
    localparam int SVGA_V_BP  = 23;

    localparam int SVGA_COLOR_W = 4;

    // Pixel at the default channel width
    typedef struct packed {
        logic [SVGA_COLOR_W-1:0] red;
        logic [SVGA_COLOR_W-1:0] green;
        logic [SVGA_COLOR_W-1:0] blue;
    } rgb_t;

    // Bundle travelling down the alignment pipeline (hs/vs already at pin level)
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Total period of one axis from its four segments
    function automatic int timing_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register with a synchronous reset value.
// pre_out is the value the last stage will load on the next enabled edge.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] pre_out,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next value of every stage is the stage in front of it
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Advance the whole line only when enabled; reset flushes to the idle value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign pre_out = stage_d[DEPTH-1];
    assign dout    = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with look-ahead pixel fetch and
// registered, mutually aligned HS/VS/DE/RGB outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACT     = SVGA_H_ACT,
    parameter int H_FP      = SVGA_H_FP,
    parameter int H_SW      = SVGA_H_SW,
    parameter int H_BP      = SVGA_H_BP,
    parameter int V_ACT     = SVGA_V_ACT,
    parameter int V_FP      = SVGA_V_FP,
    parameter int V_SW      = SVGA_V_SW,
    parameter int V_BP      = SVGA_V_BP,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int FETCH_LAT = 2,
    parameter int COLOR_W   = 4,
    parameter int FRAME_W   = 16,
    localparam int H_TOT    = timing_total(H_ACT, H_FP, H_SW, H_BP),
    localparam int V_TOT    = timing_total(V_ACT, V_FP, V_SW, V_BP),
    localparam int X_W      = $clog2(H_TOT),
    localparam int Y_W      = $clog2(V_TOT)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 pix_tick,
    output logic                 fetch_valid,
    output logic [X_W-1:0]       fetch_x,
    output logic [Y_W-1:0]       fetch_y,
    input  logic [3*COLOR_W-1:0] pix_in,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 active,
    output logic                 frame_start,
    output logic                 line_start,
    output logic [FRAME_W-1:0]   frame_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0]   H_VIS    = X_W'(H_ACT);
    localparam logic [X_W-1:0]   HS_BEGIN = X_W'(H_ACT + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACT + H_FP + H_SW);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0]   V_VIS    = Y_W'(V_ACT);
    localparam logic [Y_W-1:0]   VS_BEGIN = Y_W'(V_ACT + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACT + V_FP + V_SW);

    localparam sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    // Geometry sanity checks at elaboration
    if (H_FP < 1 || H_SW < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: horizontal porch/sync widths must be >= 1");
    end
    if (V_FP < 1 || V_SW < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: vertical porch/sync widths must be >= 1");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end
    if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : g_bad_lat
        $error("vga_timing_gen: FETCH_LAT must be in 1..8");
    end

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } pix_t;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [X_W-1:0]     h_q, h_d;
    logic [Y_W-1:0]     v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    pix_t               rgb_q, rgb_d;
    pix_t               pix_s;
    logic               tick;
    logic               h_wrap;
    logic               v_last;
    logic               hs_raw;
    logic               vs_raw;
    logic               valid_raw;
    sync_t              sync_raw;
    sync_t              sync_pre;
    sync_t              sync_out;

    assign pix_s  = pix_in;
    assign tick   = !rst && (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);

    // Decode fetch position, sync windows and the pin-level sync bundle
    always_comb begin
        valid_raw   = (h_q < H_VIS) && (v_q < V_VIS);
        hs_raw      = (h_q >= HS_BEGIN) && (h_q < HS_END);
        vs_raw      = (v_q >= VS_BEGIN) && (v_q < VS_END);
        sync_raw.hs = hs_raw ? HS_POL : ~HS_POL;
        sync_raw.vs = vs_raw ? VS_POL : ~VS_POL;
        sync_raw.de = valid_raw;
    end

    // Next-state logic for divider, raster counters, frame count and colour
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        rgb_d   = rgb_q;
        if (tick) begin
            h_d   = h_wrap ? '0 : h_q + X_W'(1);
            rgb_d = sync_pre.de ? pix_s : '0;
            if (h_wrap) begin
                v_d = v_last ? '0 : v_q + Y_W'(1);
                if (v_last) begin
                    frame_d = frame_q + FRAME_W'(1);
                end
            end
        end
    end

    // State registers; reset wins at the same edge, abandoning any partial line
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            rgb_q   <= '0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            rgb_q   <= rgb_d;
        end
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (FETCH_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (clk),
        .rst     (rst),
        .en      (tick),
        .din     (sync_raw),
        .pre_out (sync_pre),
        .dout    (sync_out)
    );

    assign pix_tick    = tick;
    assign fetch_valid = valid_raw;
    assign fetch_x     = h_q;
    assign fetch_y     = v_q;
    assign line_start  = tick && (h_q == '0);
    assign frame_start = tick && (h_q == '0) && (v_q == '0);
    assign frame_cnt   = frame_q;
    assign VGA_HS      = sync_out.hs;
    assign VGA_VS      = sync_out.vs;
    assign active      = sync_out.de;
    assign red         = rgb_q.red;
    assign green       = rgb_q.green;
    assign blue        = rgb_q.blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator on an 8x6 raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        pix_tick_a, fetch_valid_a, hs_a, vs_a, active_a, fs_a, ls_a;
    logic [2:0]  fetch_x_a, fetch_y_a;
    logic [11:0] pix_a = 12'h000;
    logic [3:0]  red_a, green_a, blue_a;
    logic [15:0] frame_a;

    logic        pix_tick_b, fetch_valid_b, hs_b, vs_b, active_b, fs_b, ls_b;
    logic [2:0]  fetch_x_b, fetch_y_b;
    logic [11:0] pix_b = 12'h000;
    logic [3:0]  red_b, green_b, blue_b;
    logic [15:0] frame_b;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACT(4), .H_FP(1), .H_SW(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SW(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .FETCH_LAT(2),
        .COLOR_W(4), .FRAME_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_tick(pix_tick_a), .fetch_valid(fetch_valid_a),
        .fetch_x(fetch_x_a), .fetch_y(fetch_y_a), .pix_in(pix_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .active(active_a),
        .frame_start(fs_a), .line_start(ls_a), .frame_cnt(frame_a)
    );

    vga_timing_gen #(
        .H_ACT(4), .H_FP(1), .H_SW(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SW(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .FETCH_LAT(2),
        .COLOR_W(4), .FRAME_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_tick(pix_tick_b), .fetch_valid(fetch_valid_b),
        .fetch_x(fetch_x_b), .fetch_y(fetch_y_b), .pix_in(pix_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .active(active_b),
        .frame_start(fs_b), .line_start(ls_b), .frame_cnt(frame_b)
    );

    // Pixel source with one clk of read latency; blanking returns all ones
    always @(posedge clk) begin
        pix_a <= fetch_valid_a ? {6'd0, fetch_x_a, fetch_y_a} : 12'hFFF;
    end

    // Compare one observed value against its hand-derived expectation
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_count++;
        if (got !== want) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Drive reset for a number of clk edges, changing it away from the active edge
    task automatic applyStimulus(input int edges);
        @(negedge clk);
        rst = 1'b1;
        repeat (edges) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int x, y, xd, yd, p, pd, xb;
        bit vd;
        int vs_low, hs_b_high;

        applyStimulus(2);
        repeat (10) @(negedge clk);

        // Reset while counters run: check idle outputs after each reset edge
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("rst_hs", hs_a, 1);
            checkOutput("rst_vs", vs_a, 1);
            checkOutput("rst_active", active_a, 0);
            checkOutput("rst_rgb", {red_a, green_a, blue_a}, 0);
            checkOutput("rst_tick", pix_tick_a, 0);
            checkOutput("rst_fs", fs_a, 0);
        end
        rst = 1'b0;
        #1;

        vs_low    = 0;
        hs_b_high = 0;
        for (int c = 0; c <= 115; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            x  = c % 8;
            y  = (c / 8) % 6;
            checkOutput("tick_a", pix_tick_a, 1);
            checkOutput("fetch_x", fetch_x_a, x);
            checkOutput("fetch_y", fetch_y_a, y);
            checkOutput("fetch_valid", fetch_valid_a, (x < 4 && y < 3) ? 1 : 0);
            checkOutput("line_start", ls_a, (x == 0) ? 1 : 0);
            checkOutput("frame_start", fs_a, (x == 0 && y == 0) ? 1 : 0);
            checkOutput("frame_cnt", frame_a, c / 48);
            if (c >= 2) begin
                xd = (c - 2) % 8;
                yd = ((c - 2) / 8) % 6;
                vd = (xd < 4 && yd < 3);
                checkOutput("hs", hs_a, (xd == 5 || xd == 6) ? 0 : 1);
                checkOutput("vs", vs_a, (yd == 4) ? 0 : 1);
                checkOutput("active", active_a, vd);
                checkOutput("rgb", {red_a, green_a, blue_a}, vd ? (xd * 8 + yd) : 0);
            end else begin
                checkOutput("hs_early", hs_a, 1);
                checkOutput("active_early", active_a, 0);
            end
            if (c < 96 && vs_a == 1'b0) vs_low++;

            // Divided instance: one tick per three clk, counters hold three clk
            p = c / 3;
            checkOutput("tick_b", pix_tick_b, (c % 3 == 2) ? 1 : 0);
            checkOutput("fetch_x_b", fetch_x_b, p % 8);
            if (p >= 2) begin
                pd = p - 2;
                xb = pd % 8;
                checkOutput("hs_b", hs_b, (xb == 5 || xb == 6) ? 1 : 0);
            end
            if (c >= 24 && c < 48 && hs_b == 1'b1) hs_b_high++;
        end
        checkOutput("vs_low_clk", vs_low, 16);
        checkOutput("hs_b_high_clk", hs_b_high, 6);

        // Now at v=2, h=3: single-clk reset mid-frame
        checkOutput("pre_rst_pos", {fetch_y_a, fetch_x_a}, {3'd2, 3'd3});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_x", fetch_x_a, 0);
        checkOutput("mid_y", fetch_y_a, 0);
        checkOutput("mid_frame", frame_a, 0);
        checkOutput("mid_active0", active_a, 0);
        checkOutput("mid_fs", fs_a, 1);
        @(negedge clk);
        #1;
        checkOutput("mid_active1", active_a, 0);
        checkOutput("mid_x1", fetch_x_a, 1);
        @(negedge clk);
        #1;
        checkOutput("mid_active2", active_a, 1);
        checkOutput("mid_rgb2", {red_a, green_a, blue_a}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
